line_memory: RTL and testbench

Parametrised, resettable main-memory model that backs the L1 caches. It serves NUM_PORTS requesters (e.g. icache and dcache) through a round-robin arbiter, one outstanding transaction at a time. Reads and writes are full-line; each request completes after a programmable transfer latency. It sits below the caches as the single backing store for the core.

---
 rtl/line_memory_pkg.sv | 24 ++
 rtl/line_memory_rr_arbiter.sv | 27 ++
 rtl/line_memory.sv | 119 +++++++++++
 tb/tb_line_memory.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_memory_pkg.sv
// Shared types and geometry helpers for the line_memory backing store.
// The helpers turn module parameters into decode widths for the importing modules.
package line_memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    function automatic int calc_offset_bits(input int line_width);
        return $clog2(line_width / 8);
    endfunction

    function automatic int calc_index_bits(input int depth);
        return $clog2(depth);
    endfunction

    // A single-port instance still needs a 1-bit pointer/grant index.
    function automatic int calc_ptr_bits(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/line_memory_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after i_ptr.
// The pointer register itself is held by the parent.
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_ptr,
    output logic [NUM_PORTS-1:0] o_grant
);

    logic [PTR_W-1:0] w_idx;

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % NUM_PORTS);
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_memory.sv
// Full-line main-memory model shared by NUM_PORTS requesters via round-robin.
// One transaction in flight; response LATENCY cycles after acceptance.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int LINE_WIDTH    = 128,
    parameter int DEPTH         = 64,
    parameter int LATENCY       = 5
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_PORTS-1:0]                      req,
    input  logic [NUM_PORTS-1:0]                      store,
    input  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0]   address,
    input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]      evict_data,
    output logic [NUM_PORTS-1:0]                      ready,
    output logic [LINE_WIDTH-1:0]                     fill_data,
    output logic [NUM_PORTS-1:0]                      response_valid
);

    localparam int OFFSET_BITS = calc_offset_bits(LINE_WIDTH);
    localparam int INDEX_BITS  = calc_index_bits(DEPTH);
    localparam int PTR_W       = calc_ptr_bits(NUM_PORTS);
    localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_t             r_state, w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [PTR_W-1:0]       r_ptr, r_gnt_idx;
    logic                   r_store;
    logic [INDEX_BITS-1:0]  r_index;
    logic [LINE_WIDTH-1:0]  r_data;
    logic [LINE_WIDTH-1:0]  r_mem [DEPTH];

    logic [NUM_PORTS-1:0]   w_grant;
    logic [PTR_W-1:0]       w_gnt_idx, w_ptr_next;
    logic [INDEX_BITS-1:0]  w_index;
    logic                   w_accept;
    logic                   w_resp;
    logic                   w_unused_addr;

    // Offset and upper address bits are deliberately ignored (aliasing).
    assign w_unused_addr = ^address;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) w_gnt_idx = PTR_W'(i);
        end
    end

    assign w_accept   = (r_state == IDLE) && (|req);
    assign w_index    = address[w_gnt_idx][OFFSET_BITS +: INDEX_BITS];
    assign w_ptr_next = (w_gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    assign w_resp     = (r_state == RESP) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = (LATENCY == 1) ? RESP : BUSY;
            BUSY:    if (r_cnt == CNT_W'(1)) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are gated by reset so they drop immediately, not at the next edge.
    always_comb begin
        ready          = '0;
        response_valid = '0;
        fill_data      = '0;
        if ((r_state == IDLE) && !reset) ready = w_grant;
        if (w_resp) begin
            response_valid[r_gnt_idx] = 1'b1;
            if (!r_store) fill_data = r_mem[r_index];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_gnt_idx <= '0;
            r_store   <= 1'b0;
            r_index   <= '0;
            r_data    <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_accept) begin
                r_cnt     <= CNT_W'(LATENCY - 1);
                r_ptr     <= w_ptr_next;
                r_gnt_idx <= w_gnt_idx;
                r_store   <= store[w_gnt_idx];
                r_index   <= w_index;
                r_data    <= evict_data[w_gnt_idx];
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // Store commits on the edge that ends RESP, so an aborted transfer never writes.
            if ((r_state == RESP) && r_store) r_mem[r_index] <= r_data;
        end
    end

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_line_memory;

    localparam int LAT = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req = '0, store = '0;
    logic [1:0][31:0]  address = '0;
    logic [1:0][127:0] evict_data = '0;
    logic [1:0]        ready, response_valid;
    logic [127:0]      fill_data;

    logic [1:0]        req1 = '0, store1 = '0;
    logic [1:0][31:0]  address1 = '0;
    logic [1:0][127:0] evict1 = '0;
    logic [1:0]        ready1, rv1;
    logic [127:0]      fill1;

    int n_vec = 0;
    int n_err = 0;

    line_memory #(.NUM_PORTS(2), .ADDRESS_WIDTH(32), .LINE_WIDTH(128), .DEPTH(64), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .store(store), .address(address),
        .evict_data(evict_data), .ready(ready), .fill_data(fill_data),
        .response_valid(response_valid)
    );

    line_memory #(.NUM_PORTS(2), .ADDRESS_WIDTH(32), .LINE_WIDTH(128), .DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .store(store1), .address(address1),
        .evict_data(evict1), .ready(ready1), .fill_data(fill1),
        .response_valid(rv1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory image, round-robin pointer, one pending transaction.
    logic [127:0] m_mem [64];
    bit           m_pend = 0;
    int           m_port, m_idx, m_ptr = 0, m_g;
    bit           m_store, m_found, m_resp_now, m_acc_now;
    logic [127:0] m_data;
    longint       cyc = 0, m_resp_cyc = 0;
    logic [1:0]   er, ev;
    logic [127:0] ef;

    always @(negedge clk) begin
        cyc++;
        er = '0; ev = '0; ef = '0;
        m_resp_now = 0; m_acc_now = 0; m_found = 0; m_g = 0;
        if (reset) begin
            chk("rst_ready", ready, 2'b00);
            chk("rst_resp_valid", response_valid, 2'b00);
            chk("rst_fill_data", fill_data, '0);
            for (int i = 0; i < 64; i++) m_mem[i] = '0;
            m_pend = 0;
            m_ptr  = 0;
        end else begin
            if (m_pend && cyc == m_resp_cyc) begin
                m_resp_now = 1;
                ev[m_port] = 1'b1;
                if (!m_store) ef = m_mem[m_idx];
            end else if (!m_pend && req != 2'b00) begin
                for (int k = 0; k < 2; k++) begin
                    if (!m_found && req[(m_ptr + k) % 2]) begin
                        m_found = 1;
                        m_g = (m_ptr + k) % 2;
                    end
                end
                m_acc_now = 1;
                er[m_g] = 1'b1;
            end
            chk("ready", ready, er);
            chk("resp_valid", response_valid, ev);
            chk("fill_data", fill_data, ef);
            if (m_resp_now) begin
                if (m_store) m_mem[m_idx] = m_data;
                m_pend = 0;
            end
            if (m_acc_now) begin
                m_pend     = 1;
                m_port     = m_g;
                m_store    = store[m_g];
                m_idx      = int'(address[m_g][9:4]);
                m_data     = evict_data[m_g];
                m_resp_cyc = cyc + LAT;
                m_ptr      = (m_g + 1) % 2;
            end
        end
    end

    // Drive a request from posedge+1 and hold it until accepted; waited = idle cycles before ready.
    task automatic issue(input int p, input bit st, input logic [31:0] a,
                         input logic [127:0] d, output int waited);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req[p] = 1'b1; store[p] = st; address[p] = a; evict_data[p] = d;
        waited = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ready[p]) begin
                got = 1;
                break;
            end
            waited++;
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: port %0d never saw ready", p);
        end
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    // Count cycles after acceptance until the response pulse (first call cycle = acceptance+1).
    task automatic wait_resp(input int p, output int lat, output logic [127:0] fd);
        lat = 0; fd = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (response_valid[p]) begin
                lat = i;
                fd  = fill_data;
                break;
            end
        end
        if (lat == 0) begin
            n_vec++; n_err++;
            $display("FAIL resp_timeout: port %0d never saw response_valid", p);
        end
    endtask

    localparam logic [127:0] D2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] DA = {32{4'hA}};
    localparam logic [127:0] D5 = {32{4'h5}};

    initial begin
        int w, lat;
        logic [127:0] fd;

        // 1: reset state, then a plain read
        repeat (2) @(negedge clk);
        chk("t1_reset_ready", ready, 2'b00);
        chk("t1_reset_resp", response_valid, 2'b00);
        @(posedge clk); #1 reset = 1'b0;
        issue(0, 0, 32'h40, '0, w);
        chk("t1_accept_wait", w, 0);
        wait_resp(0, lat, fd);
        chk("t1_latency", lat, 5);
        chk("t1_fill_zero", fd, '0);
        @(negedge clk);
        chk("t1_single_pulse", response_valid, 2'b00);

        // 2: store then read with different offset from the other port
        issue(0, 1, 32'h40, D2, w);
        wait_resp(0, lat, fd);
        chk("t2_store_latency", lat, 5);
        chk("t2_store_fill_zero", fd, '0);
        issue(1, 0, 32'h4F, '0, w);
        chk("t2_read_accept_wait", w, 0);
        wait_resp(1, lat, fd);
        chk("t2_read_latency", lat, 5);
        chk("t2_read_data", fd, D2);

        // 3: both ports held from a fresh reset
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        req = 2'b11; store = 2'b00; address = '0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("t3_ready_c%0d", k), ready,
                (k == 0 || k == 12) ? 2'b01 : (k == 6) ? 2'b10 : 2'b00);
            chk($sformatf("t3_resp_c%0d", k), response_valid,
                (k == 5) ? 2'b01 : (k == 11) ? 2'b10 : 2'b00);
        end
        @(posedge clk); #1 req = 2'b00;
        repeat (6) @(negedge clk);

        // 4: aliasing modulo DEPTH lines
        issue(0, 1, 32'h010, DA, w);
        wait_resp(0, lat, fd);
        issue(0, 0, 32'h410, '0, w);
        wait_resp(0, lat, fd);
        chk("t4_alias_data", fd, DA);

        // 5: reset in the middle of a read drops it and clears memory
        issue(0, 1, 32'h80, D5, w);
        wait_resp(0, lat, fd);
        issue(0, 0, 32'h80, '0, w);
        @(posedge clk); #1;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("t5_reset_resp", response_valid, 2'b00);
        @(posedge clk); #1 reset = 1'b0;
        req[0] = 1'b1; store[0] = 1'b0; address[0] = 32'h80;
        @(negedge clk);
        chk("t5_ready_after_reset", ready, 2'b01);
        @(posedge clk); #1 req[0] = 1'b0;
        wait_resp(0, lat, fd);
        chk("t5_latency", lat, 5);
        chk("t5_cleared_data", fd, '0);

        // 6: LATENCY=1 instance with a held request
        @(posedge clk); #1;
        req1 = 2'b01; store1 = 2'b00; address1 = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t6_ready_c%0d", k), ready1, (k % 2 == 0) ? 2'b01 : 2'b00);
            chk($sformatf("t6_resp_c%0d", k), rv1, (k % 2 == 1) ? 2'b01 : 2'b00);
            chk($sformatf("t6_fill_c%0d", k), fill1, '0);
        end
        @(posedge clk); #1 req1 = 2'b00;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
